// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the
// shared single-port memory. The arbiter uses the slave view; the requesters
// and the memory model use the master view.
interface mem_arbiter_if;
    // instruction-fetch side
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    // data side
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    // shared memory port
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_out;
    // status
    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
        output i_ack, i_rdata, d_ack, d_rdata,
               mem_addr, mem_data_in, mem_enable, mem_wr, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
        input  i_ack, i_rdata, d_ack, d_rdata,
               mem_addr, mem_data_in, mem_enable, mem_wr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory. The data side normally
// wins contention, but after MAX_D_BURST consecutive data grants made while an
// instruction fetch was waiting, the fetch is served.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requests, pick a winner, capture its transaction
// ACCESS | drive the memory port from captured values, latch read data
// RESP   | pulse the winner's ack for one cycle
module mem_arbiter #(
    parameter int unsigned MAX_D_BURST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] STREAK_MAX = 3'(MAX_D_BURST);

    state_t      state_q, state_d;
    logic        win_d_q, win_d_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [2:0]  streak_q, streak_d;
    logic [15:0] i_rdata_q, i_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        grant_d;

    // Register all state; reset clears everything so outputs fall to 0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_d_q   <= 1'b0;
            addr_q    <= 16'h0000;
            wr_q      <= 1'b0;
            wdata_q   <= 16'h0000;
            streak_q  <= 3'd0;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            win_d_q   <= win_d_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            streak_q  <= streak_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Next-state, arbitration, capture and memory/ack outputs.
    always_comb begin
        state_d         = state_q;
        win_d_d         = win_d_q;
        addr_d          = addr_q;
        wr_d            = wr_q;
        wdata_d         = wdata_q;
        streak_d        = streak_q;
        i_rdata_d       = i_rdata_q;
        d_rdata_d       = d_rdata_q;
        grant_d         = 1'b0;
        bus.mem_enable  = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = 16'h0000;
        bus.mem_data_in = 16'h0000;
        bus.i_ack       = 1'b0;
        bus.d_ack       = 1'b0;
        bus.busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // D wins unless it has already starved a waiting fetch long enough.
                    grant_d = bus.d_req && (!bus.i_req || (streak_q != STREAK_MAX));
                    win_d_d = grant_d;
                    addr_d  = grant_d ? bus.d_addr : bus.i_addr;
                    wr_d    = grant_d && bus.d_wr;
                    wdata_d = bus.d_wdata;
                    if (!grant_d) begin
                        streak_d = 3'd0;
                    end else if (bus.i_req && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + 3'd1;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_enable  = 1'b1;
                bus.mem_addr    = addr_q;
                bus.mem_wr      = wr_q;
                bus.mem_data_in = wdata_q;
                if (!win_d_q) begin
                    i_rdata_d = bus.mem_data_out;
                end else if (!wr_q) begin
                    d_rdata_d = bus.mem_data_out;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.i_ack = !win_d_q;
                bus.d_ack = win_d_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a cycle-timeline reference model.
module tb_mem_arbiter;
    localparam int MAX_D_BURST = 2;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_D_BURST(MAX_D_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, write at clock edge, backdoor preload port
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [15:0] bd_data;

    assign bus.mem_data_out = bus.mem_enable ? mem[bus.mem_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.mem_enable && bus.mem_wr) mem[bus.mem_addr[7:0]] <= bus.mem_data_in;
    end

    task automatic idle_inputs;
        bus.i_req = 1'b0; bus.i_addr = 16'h0000;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        bd_we = 1'b0;
        idle_inputs();
        #1 rst_n = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0001;
        bus.d_req = 1'b1; bus.d_addr = 16'h0002;
        #2;
        checks++;
        if ({bus.busy, bus.i_ack, bus.d_ack, bus.mem_enable, bus.mem_wr} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl_async got=%b exp=00000",
                     {bus.busy, bus.i_ack, bus.d_ack, bus.mem_enable, bus.mem_wr});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_data_in} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data_async got=%h exp=0",
                     {bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_data_in});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.mem_enable, bus.i_ack, bus.d_ack} !== 4'b0) begin
            failures++;
            $display("FAIL reset_held got=%b exp=0000",
                     {bus.busy, bus.mem_enable, bus.i_ack, bus.d_ack});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_enable !== 1'b1 || bus.mem_addr !== 16'h0002) begin
            failures++;
            $display("FAIL reset_first_sample got en=%b addr=%h exp en=1 addr=0002",
                     bus.mem_enable, bus.mem_addr);
        end
        do_reset();
    endtask

    task automatic test_i_fetch;
        preload(8'h00, 16'h1234);
        bus.i_req = 1'b1; bus.i_addr = 16'h0000;
        @(negedge clk);
        checks++;
        if ({bus.mem_enable, bus.mem_wr, bus.busy, bus.i_ack} !== 4'b1010 || bus.mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL ifetch_access got en/wr/busy/ack=%b addr=%h exp 1010 addr=0000",
                     {bus.mem_enable, bus.mem_wr, bus.busy, bus.i_ack}, bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0 || bus.i_rdata !== 16'h1234 || bus.mem_enable !== 1'b0) begin
            failures++;
            $display("FAIL ifetch_ack got iack=%b dack=%b rdata=%h en=%b exp 1 0 1234 0",
                     bus.i_ack, bus.d_ack, bus.i_rdata, bus.mem_enable);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.i_ack !== 1'b0 || bus.i_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL ifetch_after got busy=%b iack=%b rdata=%h exp 0 0 1234",
                     bus.busy, bus.i_ack, bus.i_rdata);
        end
    endtask

    task automatic test_write_read;
        int wr_cnt = 0;
        int iack_cnt = 0;
        bit got = 0;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'hBEEF;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.i_ack) iack_cnt++;
            if (bus.mem_wr) begin
                wr_cnt++;
                checks++;
                if (bus.mem_addr !== 16'h0010 || bus.mem_data_in !== 16'hBEEF || bus.mem_enable !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_strobe got addr=%h data=%h en=%b exp 0010 beef 1",
                             bus.mem_addr, bus.mem_data_in, bus.mem_enable);
                end
            end
            if (bus.d_ack) begin
                got = 1;
                bus.d_req = 1'b0;
                checks++;
                if (bus.d_rdata !== 16'h0000) begin
                    failures++;
                    $display("FAIL wr_no_rdata got=%h exp=0000", bus.d_rdata);
                end
            end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL wr_ack_timeout got=none exp=d_ack"); end
        ref_mem[8'h10] = 16'hBEEF;
        got = 0;
        bus.d_req = 1'b1; bus.d_wr = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.i_ack) iack_cnt++;
            if (bus.mem_wr) wr_cnt++;
            if (bus.d_ack) begin
                got = 1;
                bus.d_req = 1'b0;
                checks++;
                if (bus.d_rdata !== ref_mem[8'h10]) begin
                    failures++;
                    $display("FAIL rd_data got=%h exp=%h", bus.d_rdata, ref_mem[8'h10]);
                end
            end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL rd_ack_timeout got=none exp=d_ack"); end
        checks++;
        if (wr_cnt != 1) begin failures++; $display("FAIL wr_count got=%0d exp=1", wr_cnt); end
        checks++;
        if (iack_cnt != 0) begin failures++; $display("FAIL wr_iack got=%0d exp=0", iack_cnt); end
    endtask

    task automatic test_contention;
        bit exp_d [6] = '{1, 1, 0, 1, 1, 0};
        int n = 0;
        int last = 0;
        int t = 0;
        do_reset();
        preload(8'h30, 16'h3030);
        preload(8'h31, 16'h3131);
        bus.i_req = 1'b1; bus.i_addr = 16'h0030;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0031;
        while (n < 6 && t < 40) begin
            @(negedge clk);
            t++;
            if (bus.i_ack || bus.d_ack) begin
                checks++;
                if (bus.d_ack !== exp_d[n] || bus.i_ack !== !exp_d[n]) begin
                    failures++;
                    $display("FAIL contend_order_%0d got d=%b i=%b exp d=%b", n, bus.d_ack, bus.i_ack, exp_d[n]);
                end
                checks++;
                if ((exp_d[n] && bus.d_rdata !== 16'h3131) || (!exp_d[n] && bus.i_rdata !== 16'h3030)) begin
                    failures++;
                    $display("FAIL contend_data_%0d got i=%h d=%h", n, bus.i_rdata, bus.d_rdata);
                end
                if (n > 0) begin
                    checks++;
                    if (t - last != 3) begin
                        failures++;
                        $display("FAIL contend_gap_%0d got=%0d exp=3", n, t - last);
                    end
                end
                last = t;
                n++;
            end
        end
        checks++;
        if (n != 6) begin failures++; $display("FAIL contend_timeout got=%0d exp=6", n); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_streak_d_only;
        int n = 0;
        int t = 0;
        do_reset();
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0031;
        bus.i_addr = 16'h0030;
        while (n < 8 && t < 60) begin
            @(negedge clk);
            t++;
            if (bus.i_ack || bus.d_ack) begin
                // first five D-only, then with both requesting: D, D, I
                checks++;
                if (bus.d_ack !== (n != 7)) begin
                    failures++;
                    $display("FAIL streak_order_%0d got d=%b i=%b exp d=%b", n, bus.d_ack, bus.i_ack, n != 7);
                end
                n++;
                if (n == 5) bus.i_req = 1'b1;
            end
        end
        checks++;
        if (n != 8) begin failures++; $display("FAIL streak_timeout got=%0d exp=8", n); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int dack = 0;
        bit got = 0;
        do_reset();
        preload(8'h20, 16'h5555);
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'hAAAA;
        @(negedge clk);
        checks++;
        if (bus.mem_wr !== 1'b1) begin failures++; $display("FAIL abort_pre_wr got=%b exp=1", bus.mem_wr); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.i_ack, bus.d_ack, bus.mem_enable, bus.mem_wr} !== 5'b0) begin
            failures++;
            $display("FAIL abort_ctrl got=%b exp=00000",
                     {bus.busy, bus.i_ack, bus.d_ack, bus.mem_enable, bus.mem_wr});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_data_in} !== 64'h0) begin
            failures++;
            $display("FAIL abort_data got=%h exp=0",
                     {bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_data_in});
        end
        bus.d_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.d_ack) dack++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.d_ack) dack++;
        end
        checks++;
        if (dack != 0) begin failures++; $display("FAIL abort_no_ack got=%0d exp=0", dack); end
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0020;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                got = 1;
                bus.d_req = 1'b0;
                checks++;
                if (bus.d_rdata !== 16'h5555) begin
                    failures++;
                    $display("FAIL abort_readback got=%h exp=5555", bus.d_rdata);
                end
            end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL abort_read_timeout got=none exp=d_ack"); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int t = 0;
        int last = 0;
        do_reset();
        for (int k = 0; k < 4; k++) preload(8'(k), 16'hA000 + 16'(k));
        bus.i_req = 1'b1; bus.i_addr = 16'h0000;
        while (n < 4 && t < 40) begin
            @(negedge clk);
            t++;
            if (bus.mem_enable) begin
                bus.i_addr = 16'h00F0 + 16'(n);
                #1;
                checks++;
                if (bus.mem_addr !== 16'(n)) begin
                    failures++;
                    $display("FAIL b2b_addr_%0d got=%h exp=%h", n, bus.mem_addr, 16'(n));
                end
            end
            if (bus.i_ack) begin
                checks++;
                if (bus.i_rdata !== ref_mem[8'(n)]) begin
                    failures++;
                    $display("FAIL b2b_data_%0d got=%h exp=%h", n, bus.i_rdata, ref_mem[8'(n)]);
                end
                if (n > 0) begin
                    checks++;
                    if (t - last != 3) begin
                        failures++;
                        $display("FAIL b2b_gap_%0d got=%0d exp=3", n, t - last);
                    end
                end
                last = t;
                n++;
                bus.i_addr = 16'(n);
            end
        end
        checks++;
        if (n != 4) begin failures++; $display("FAIL b2b_timeout got=%0d exp=4", n); end
        idle_inputs();
        @(negedge clk);
    endtask

    // Timeline model: a grant at edge g puts the memory access after g, the
    // ack after g+1, and the next possible sample at g+3.
    task automatic test_random;
        bit          i_pend = 0, d_pend = 0;
        bit          have_grant = 0, win_d = 0, cap_wr = 0;
        int          grant_t = -10;
        int          streak = 0;
        logic [15:0] cap_addr = 0, cap_wdata = 0, exp_rd = 0;
        logic [15:0] i_last = 0, d_last = 0;
        bit          exp_en, exp_busy, exp_iack, exp_dack;
        do_reset();
        for (int a = 0; a < 16; a++) preload(8'(a), 16'($urandom));
        for (int t = 0; t < 600; t++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; bus.i_addr = 16'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; bus.d_addr = 16'($urandom_range(0, 15));
                bus.d_wr = 1'($urandom_range(0, 1)); bus.d_wdata = 16'($urandom);
            end
            if (have_grant && grant_t == t - 1) begin
                if (win_d) begin
                    bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom); bus.d_wr = 1'($urandom_range(0, 1));
                end else begin
                    bus.i_addr = 16'($urandom);
                end
            end
            bus.i_req = i_pend; bus.d_req = d_pend;
            @(posedge clk);
            if ((!have_grant || t >= grant_t + 3) && (i_pend || d_pend)) begin
                win_d = d_pend && (!i_pend || streak < MAX_D_BURST);
                if (!win_d) streak = 0;
                else if (i_pend && streak < MAX_D_BURST) streak++;
                cap_addr  = win_d ? bus.d_addr : bus.i_addr;
                cap_wr    = win_d && bus.d_wr;
                cap_wdata = bus.d_wdata;
                if (cap_wr) ref_mem[cap_addr[7:0]] = cap_wdata;
                else exp_rd = ref_mem[cap_addr[7:0]];
                grant_t = t; have_grant = 1;
            end
            @(negedge clk);
            exp_en   = have_grant && t == grant_t;
            exp_busy = have_grant && (t == grant_t || t == grant_t + 1);
            exp_iack = have_grant && t == grant_t + 1 && !win_d;
            exp_dack = have_grant && t == grant_t + 1 && win_d;
            checks++;
            if ({bus.busy, bus.mem_enable, bus.mem_wr, bus.i_ack, bus.d_ack} !==
                {exp_busy, exp_en, exp_en && cap_wr, exp_iack, exp_dack}) begin
                failures++;
                $display("FAIL rand_ctrl t=%0d got busy/en/wr/iack/dack=%b exp=%b", t,
                         {bus.busy, bus.mem_enable, bus.mem_wr, bus.i_ack, bus.d_ack},
                         {exp_busy, exp_en, exp_en && cap_wr, exp_iack, exp_dack});
            end
            checks++;
            if (exp_en) begin
                if (bus.mem_addr !== cap_addr || (cap_wr && bus.mem_data_in !== cap_wdata)) begin
                    failures++;
                    $display("FAIL rand_mem t=%0d got addr=%h din=%h exp addr=%h din=%h", t,
                             bus.mem_addr, bus.mem_data_in, cap_addr, cap_wdata);
                end
            end else if ({bus.mem_addr, bus.mem_data_in} !== 32'h0) begin
                failures++;
                $display("FAIL rand_mem_idle t=%0d got=%h exp=0", t, {bus.mem_addr, bus.mem_data_in});
            end
            if (exp_iack) i_last = exp_rd;
            if (exp_dack && !cap_wr) d_last = exp_rd;
            checks++;
            if (bus.i_rdata !== i_last || bus.d_rdata !== d_last) begin
                failures++;
                $display("FAIL rand_rdata t=%0d got i=%h d=%h exp i=%h d=%h", t,
                         bus.i_rdata, bus.d_rdata, i_last, d_last);
            end
            if (exp_iack) begin
                i_pend = 1'($urandom_range(0, 1));
                if (i_pend) bus.i_addr = 16'($urandom_range(0, 15));
            end
            if (exp_dack) begin
                d_pend = 1'($urandom_range(0, 1));
                if (d_pend) begin
                    bus.d_addr = 16'($urandom_range(0, 15));
                    bus.d_wr = 1'($urandom_range(0, 1)); bus.d_wdata = 16'($urandom);
                end
            end
        end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_i_fetch();
        test_write_read();
        test_contention();
        test_streak_d_only();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
